// File: rtl/apo_router_in_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apo_router_in_queue_if                                                     |
// | Port bundle between the router input-queue stage and its neighbours.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface apo_router_in_queue_if #(
  parameter int PKT_W = 15,
  parameter int CNT_W = 8
) ();
  logic [PKT_W-1:0] in_free;
  logic [PKT_W-1:0] in_r1R;
  logic [PKT_W-1:0] in_r2R;
  logic [PKT_W-1:0] in_r1L;
  logic [PKT_W-1:0] in_r2L;
  logic [PKT_W-1:0] out_free;
  logic [PKT_W-1:0] out_r1R;
  logic [PKT_W-1:0] out_r2R;
  logic [PKT_W-1:0] out_r1L;
  logic [PKT_W-1:0] out_r2L;
  logic             clr_ovf;
  logic [4:0]       ovf;
  logic [CNT_W-1:0] drop_cnt;
  logic             busy;

  modport master (
    output in_free, in_r1R, in_r2R, in_r1L, in_r2L, clr_ovf,
    input  out_free, out_r1R, out_r2R, out_r1L, out_r2L, ovf, drop_cnt, busy
  );

  modport slave (
    input  in_free, in_r1R, in_r2R, in_r1L, in_r2L, clr_ovf,
    output out_free, out_r1R, out_r2R, out_r1L, out_r2L, ovf, drop_cnt, busy
  );
endinterface
`default_nettype wire

// File: rtl/apo_router_in_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apo_router_in_queue                                                        |
// | Per-port FIFOs in front of a circulant router; issues one packet per cycle.|
// | Optional macro APO_Q_RR_EN selects round-robin instead of fixed priority.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module apo_router_in_queue #(
  parameter int PKT_W = 15,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  apo_router_in_queue_if.slave  bus
);

  localparam int NP = 5;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PKT_W-1:0] w_in   [NP];
  logic [PKT_W-1:0] w_head [NP];
  logic [NP-1:0]    w_req;
  logic [NP-1:0]    w_grant;
  logic [NP-1:0]    w_drop;
  logic [NP-1:0]    w_nz_nxt;
  logic [2:0]       w_start;
  logic [3:0]       w_idx;
  logic             w_found;
  logic [2:0]       w_drop_num;
  logic [CNT_W:0]   w_drop_sum;

  logic [PKT_W-1:0] r_out [NP];
  logic [NP-1:0]    r_ovf;
  logic [CNT_W-1:0] r_drop_cnt;
  logic             r_busy;
  logic             r_arm;

  assign w_in[0] = bus.in_free;
  assign w_in[1] = bus.in_r1R;
  assign w_in[2] = bus.in_r2R;
  assign w_in[3] = bus.in_r1L;
  assign w_in[4] = bus.in_r2L;

  generate
    for (genvar p = 0; p < NP; p++) begin : g_port
      logic [PKT_W-1:0] r_mem [DEPTH];
      logic [AW-1:0]    r_wr_ptr;
      logic [AW-1:0]    r_rd_ptr;
      logic [CW-1:0]    r_cnt;
      logic [CW-1:0]    w_cnt_nxt;
      logic             w_vld;
      logic             w_full;
      logic             w_push;
      logic             w_pop;

      // r_arm blocks the edge on which reset is released from capturing a packet
      assign w_vld      = r_arm & w_in[p][PKT_W-1];
      assign w_full     = (r_cnt == CW'(DEPTH));
      assign w_pop      = w_grant[p];
      assign w_push     = w_vld & (~w_full | w_pop);
      assign w_drop[p]  = w_vld & w_full & ~w_pop;
      assign w_req[p]   = (r_cnt != '0);
      assign w_head[p]  = r_mem[r_rd_ptr];
      assign w_nz_nxt[p] = (w_cnt_nxt != '0);

      always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push && !w_pop) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end else if (w_pop && !w_push) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_cnt    <= '0;
        end else begin
          if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
          if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
          r_cnt <= w_cnt_nxt;
        end
      end

      always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_in[p];
      end
    end
  endgenerate

`ifdef APO_Q_RR_EN
  logic [2:0] r_last;
  logic [2:0] w_gidx;

  assign w_start = (r_last == 3'd4) ? 3'd0 : r_last + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 3'd0;
    end else if (w_found) begin
      r_last <= w_gidx;
    end
  end
`else
  assign w_start = 3'd0;
`endif

  // Grant the first requester found walking forward from w_start, modulo 5
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_idx   = 4'd0;
`ifdef APO_Q_RR_EN
    w_gidx  = 3'd0;
`endif
    for (int k = 0; k < NP; k++) begin
      w_idx = {1'b0, w_start} + 4'(k);
      if (w_idx >= 4'd5) w_idx = w_idx - 4'd5;
      if (!w_found && w_req[w_idx[2:0]]) begin
        w_grant[w_idx[2:0]] = 1'b1;
        w_found             = 1'b1;
`ifdef APO_Q_RR_EN
        w_gidx              = w_idx[2:0];
`endif
      end
    end
  end

  always_comb begin
    w_drop_num = 3'd0;
    for (int p = 0; p < NP; p++) begin
      w_drop_num = w_drop_num + {2'b00, w_drop[p]};
    end
  end

  assign w_drop_sum = {1'b0, r_drop_cnt} + (CNT_W+1)'(w_drop_num);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NP; p++) r_out[p] <= '0;
      r_ovf      <= '0;
      r_drop_cnt <= '0;
      r_busy     <= 1'b0;
      r_arm      <= 1'b0;
    end else begin
      r_arm <= 1'b1;
      for (int p = 0; p < NP; p++) begin
        r_out[p] <= w_grant[p] ? w_head[p] : '0;
      end
      r_busy <= |w_nz_nxt;
      if (bus.clr_ovf) begin
        r_ovf      <= '0;
        r_drop_cnt <= '0;
      end else begin
        r_ovf      <= r_ovf | w_drop;
        r_drop_cnt <= w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];
      end
    end
  end

  assign bus.out_free = r_out[0];
  assign bus.out_r1R  = r_out[1];
  assign bus.out_r2R  = r_out[2];
  assign bus.out_r1L  = r_out[3];
  assign bus.out_r2L  = r_out[4];
  assign bus.ovf      = r_ovf;
  assign bus.drop_cnt = r_drop_cnt;
  assign bus.busy     = r_busy;

endmodule
`default_nettype wire
